// File: rtl/imm_gen.sv
// RV32I immediate generator: combinational decode of the immediate field by
// format select, plus a one-cycle registered copy with a valid flag.
module imm_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [2:0]  imm_sel,
  input  logic        in_valid,
  output logic [31:0] imm_out,
  output logic [31:0] imm_q,
  output logic        imm_q_valid,
  output logic        imm_illegal
);

  typedef enum logic [2:0] {
    SEL_I     = 3'b000,
    SEL_S     = 3'b001,
    SEL_B     = 3'b010,
    SEL_U     = 3'b011,
    SEL_J     = 3'b100,
    SEL_ZIMM  = 3'b101,
    SEL_SHAMT = 3'b110,
    SEL_RSVD  = 3'b111
  } imm_sel_e;

  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_sign;
  logic [31:0] r_imm_q;
  logic        r_imm_q_valid;

  assign w_sign = instr[31];

  // Opcode bits [6:0] never feed any format.
  always_comb begin
    w_imm     = 32'h0;
    w_illegal = 1'b0;
    case (imm_sel_e'(imm_sel))
      SEL_I:     w_imm = {{20{w_sign}}, instr[31:20]};
      SEL_S:     w_imm = {{20{w_sign}}, instr[31:25], instr[11:7]};
      SEL_B:     w_imm = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      SEL_U:     w_imm = {instr[31:12], 12'h000};
      SEL_J:     w_imm = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      SEL_ZIMM:  w_imm = {27'h0, instr[19:15]};
      SEL_SHAMT: w_imm = {27'h0, instr[24:20]};
      SEL_RSVD: begin
        w_imm     = 32'h0;
        w_illegal = 1'b1;
      end
      default: begin
        w_imm     = 32'h0;
        w_illegal = 1'b0;
      end
    endcase
  end

  assign imm_out     = w_imm;
  assign imm_illegal = w_illegal;

  // Valid-only handshake: in_valid qualifies instr/imm_sel for one cycle, the
  // result is presented on imm_q with imm_q_valid exactly one cycle later; there
  // is no ready, so every valid beat is accepted and imm_q holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imm_q       <= 32'h0;
      r_imm_q_valid <= 1'b0;
    end else if (in_valid) begin
      r_imm_q       <= w_imm;
      r_imm_q_valid <= 1'b1;
    end else begin
      r_imm_q_valid <= 1'b0;
    end
  end

  assign imm_q       = r_imm_q;
  assign imm_q_valid = r_imm_q_valid;

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: format table, registered stage, reset
// override and a random sweep scored against an independent reference model.
module tb_imm_gen;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic        in_valid;
  logic [31:0] imm_out;
  logic [31:0] imm_q;
  logic        imm_q_valid;
  logic        imm_illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_q;

  imm_gen dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .imm_sel     (imm_sel),
    .in_valid    (in_valid),
    .imm_out     (imm_out),
    .imm_q       (imm_q),
    .imm_q_valid (imm_q_valid),
    .imm_illegal (imm_illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: left-justify the scattered field, then arithmetic-shift down.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    logic [31:0] t;
    case (sel)
      3'd0: ref_imm = $signed(ins) >>> 20;
      3'd1: begin t = {ins[31:25], ins[11:7], 20'h0}; ref_imm = $signed(t) >>> 20; end
      3'd2: begin
        t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'h0};
        ref_imm = $signed(t) >>> 19;
      end
      3'd3: ref_imm = ins & 32'hFFFF_F000;
      3'd4: begin
        t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'h0};
        ref_imm = $signed(t) >>> 11;
      end
      3'd5: ref_imm = {27'h0, ins[19:15]};
      3'd6: ref_imm = {27'h0, ins[24:20]};
      default: ref_imm = 32'h0;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [31:0] ins, input logic [2:0] sel,
                       input logic v, input logic r);
    instr    = ins;
    imm_sel  = sel;
    in_valid = v;
    rst      = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(32'h8000_0000, 3'd0, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (imm_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_imm_q: got %h expected %h", imm_q, 32'h0);
    end
    checks++;
    if (imm_q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", imm_q_valid);
    end
    // combinational path must be live while rst is held
    checks++;
    if (imm_out !== 32'hFFFF_F800) begin
      errors++;
      $display("FAIL comb_during_rst: got %h expected %h", imm_out, 32'hFFFF_F800);
    end
    held_q = 32'h0;
  endtask

  task automatic test_formats();
    logic [31:0] t_ins[14] = '{32'h7FF0_0000, 32'h8000_0000, 32'h1230_0000, 32'h1234_5000,
                               32'hFFFF_F000, 32'h0000_A223, 32'hFE00_2423, 32'h0400_0063,
                               32'hFE00_00E3, 32'h0040_00EF, 32'h801F_F06F, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [2:0]  t_sel[14] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd1, 3'd1, 3'd2, 3'd2,
                               3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] t_exp[14] = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0123, 32'h1234_5000,
                               32'hFFFF_F000, 32'h0000_0004, 32'hFFFF_FFE8, 32'h0000_0040,
                               32'hFFFF_FFE0, 32'h0000_0004, 32'hFFFF_F800, 32'h0000_001F,
                               32'h0000_001F, 32'h0000_0000};
    logic [31:0] e;
    for (int i = 0; i < 14; i++) begin
      drive(t_ins[i], t_sel[i], 1'b0, 1'b0);
      exp_q.push_back(t_exp[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (imm_out !== e) begin
        errors++;
        $display("FAIL format_%0d sel=%0d instr=%h: got %h expected %h",
                 i, t_sel[i], t_ins[i], imm_out, e);
      end
      checks++;
      if (imm_illegal !== (t_sel[i] == 3'd7)) begin
        errors++;
        $display("FAIL illegal_%0d sel=%0d: got %b expected %b",
                 i, t_sel[i], imm_illegal, t_sel[i] == 3'd7);
      end
    end
    tick();
  endtask

  task automatic test_registered();
    logic [31:0] e;
    drive(32'h8000_0000, 3'd0, 1'b1, 1'b0);
    exp_q.push_back(32'hFFFF_F800);
    tick();
    e = exp_q.pop_front();
    held_q = e;
    checks++;
    if (imm_q !== e || imm_q_valid !== 1'b1) begin
      errors++;
      $display("FAIL reg_capture: got %h/%b expected %h/1", imm_q, imm_q_valid, e);
    end
    drive(32'h1234_5678, 3'd3, 1'b0, 1'b0);
    tick();
    checks++;
    if (imm_q !== held_q || imm_q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold: got %h/%b expected %h/0", imm_q, imm_q_valid, held_q);
    end
    // reserved select with valid registers zero but still flags valid
    drive(32'hFFFF_FFFF, 3'd7, 1'b1, 1'b0);
    tick();
    held_q = 32'h0;
    checks++;
    if (imm_q !== 32'h0 || imm_q_valid !== 1'b1) begin
      errors++;
      $display("FAIL reg_reserved: got %h/%b expected 0/1", imm_q, imm_q_valid);
    end
  endtask

  task automatic test_reset_override();
    logic [31:0] e;
    drive(32'h7FF0_0000, 3'd0, 1'b1, 1'b0);
    tick();
    drive(32'h8000_0000, 3'd0, 1'b1, 1'b1);
    tick();
    held_q = 32'h0;
    checks++;
    if (imm_q !== 32'h0 || imm_q_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_override: got %h/%b expected 0/0", imm_q, imm_q_valid);
    end
    drive(32'h004000EF, 3'd4, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0004);
    tick();
    e = exp_q.pop_front();
    held_q = e;
    checks++;
    if (imm_q !== e || imm_q_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_after_rst: got %h/%b expected %h/1", imm_q, imm_q_valid, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [31:0] e;
    logic [2:0]  sel;
    logic        v;
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      sel = 3'($urandom_range(0, 7));
      v   = (i < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      // flip opcode bits; expectation is computed from the unflipped word
      drive(ins ^ {25'h0, 7'($urandom_range(1, 127))}, sel, v, 1'b0);
      if (v) exp_q.push_back(ref_imm(ins, sel));
      #1;
      checks++;
      if (imm_out !== ref_imm(ins, sel) || imm_illegal !== (sel == 3'd7)) begin
        errors++;
        $display("FAIL sweep_comb_%0d sel=%0d instr=%h: got %h/%b expected %h/%b",
                 i, sel, instr, imm_out, imm_illegal, ref_imm(ins, sel), sel == 3'd7);
      end
      tick();
      if (v) begin
        e = exp_q.pop_front();
        held_q = e;
      end
      checks++;
      if (imm_q !== held_q || imm_q_valid !== v) begin
        errors++;
        $display("FAIL sweep_reg_%0d: got %h/%b expected %h/%b",
                 i, imm_q, imm_q_valid, held_q, v);
      end
    end
  endtask

  initial begin
    drive(32'h0, 3'd0, 1'b0, 1'b1);
    test_reset();
    test_formats();
    test_registered();
    test_reset_override();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
